rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_rom_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//   Two-requester, round-robin arbiter in front of a single asynchronous ROM.
//   Requesters use a four-phase req/ack handshake. The ROM side is a
//   two-phase interface: every toggle of romTrigger starts one access. The
//   asynchronous romReady level is synchronized before use. Data is captured
//   once WAIT_CYCLES have elapsed and ready is seen, or is forced when the
//   WAIT counter reaches TIMEOUT (which also sets the sticky timeoutErr).
//
// Ports
//   clk, rst_n      : rising-edge clock, synchronous active-low reset
//   req0/req1       : four-phase requests (0 = fetch, 1 = literal load)
//   addr0/addr1     : word addresses, stable while the matching req is high
//   ack0/ack1       : four-phase acknowledges; rdata is valid while high
//   rdata           : shared read-data register
//   romAddr         : registered ROM address (changes only on a grant)
//   romTrigger      : two-phase ROM request (toggles only in ISSUE)
//   romData         : ROM read data
//   romReady        : asynchronous ROM ready level
//   busy            : high whenever the FSM is not IDLE
//   timeoutErr      : sticky; set when a capture was forced by timeout
// -----------------------------------------------------------------------------
module rom_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic [31:0] romAddr,
  output logic        romTrigger,
  input  logic [31:0] romData,
  input  logic        romReady,
  output logic        busy,
  output logic        timeoutErr
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            grant_q, grant_d;
  logic            cancel_q, cancel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            trig_q, trig_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic            terr_q, terr_d;
  logic            ready_meta_q, ready_sync_q;

  // Working signals of the next-state logic.
  logic            req_g;
  logic            win;
  logic            ready_ok;
  logic            tmo;
  logic            abort;

  // ---------------------------------------------------------------------------
  // State register (also holds the datapath registers).
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed by the combinational process.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      cancel_q     <= 1'b0;
      cnt_q        <= '0;
      trig_q       <= 1'b0;
      addr_q       <= '0;
      rdata_q      <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      terr_q       <= 1'b0;
      ready_meta_q <= 1'b0;
      ready_sync_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cancel_q     <= cancel_d;
      cnt_q        <= cnt_d;
      trig_q       <= trig_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      terr_q       <= terr_d;
      // Two-flop synchronizer for the asynchronous ready level.
      ready_meta_q <= romReady;
      ready_sync_q <= ready_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic.
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case statement; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cancel_d     = cancel_q;
    cnt_d        = cnt_q;
    trig_d       = trig_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    ack0_d       = ack0_q;
    ack1_d       = ack1_q;
    terr_d       = terr_q;
    win          = 1'b0;
    ready_ok     = 1'b0;
    tmo          = 1'b0;
    abort        = 1'b0;

    // Request line of the current grantee.
    req_g = grant_q ? req1 : req0;

    unique case (state_q)
      S_IDLE: begin
        if ((req0 || req1) && !ack0_q && !ack1_q) begin
          // Round robin: on contention the requester that did not win last
          // time is served; otherwise the sole requester wins.
          win          = (req0 && req1) ? ~last_grant_q : req1;
          grant_d      = win;
          last_grant_d = win;
          addr_d       = win ? addr1 : addr0;
          cancel_d     = 1'b0;
          state_d      = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // romAddr was loaded on the grant edge, so it has been stable for a
        // full cycle before the trigger toggles here.
        trig_d  = ~trig_q;
        cnt_d   = '0;
        if (!req_g) cancel_d = 1'b1;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        ready_ok = (int'(cnt_q) >= WAIT_CYCLES) && ready_sync_q;
        tmo      = (cnt_q == TMO_VAL);
        if (!tmo) cnt_d = cnt_q + 1'b1;
        // A grantee that withdrew its request still lets the ROM access
        // finish, but receives neither data nor an ack.
        abort = cancel_q || !req_g;
        if (!req_g) cancel_d = 1'b1;
        if (ready_ok || tmo) begin
          if (!ready_ok) terr_d = 1'b1;
          if (abort) begin
            state_d = S_IDLE;
          end else begin
            rdata_d = romData;
            if (grant_q) ack1_d = 1'b1;
            else         ack0_d = 1'b1;
            state_d = S_ACK;
          end
        end
      end

      S_ACK: begin
        // Return to IDLE only; a waiting requester is granted next cycle.
        if (!req_g) begin
          ack0_d  = 1'b0;
          ack1_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy       = (state_q != S_IDLE);
    ack0       = ack0_q;
    ack1       = ack1_q;
    rdata      = rdata_q;
    romAddr    = addr_q;
    romTrigger = trig_q;
    timeoutErr = terr_q;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
//   Directed self-checking bench for rom_arbiter. The ROM is modelled as a
//   pure function of romAddr; ready is driven directly by the bench.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        ack0, ack1;
  logic [31:0] rdata;
  logic [31:0] rom_addr;
  logic        rom_trigger;
  logic [31:0] rom_data;
  logic        rom_ready;
  logic        busy;
  logic        timeout_err;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic        exp_trig;

  rom_arbiter #(
    .WAIT_CYCLES(2),
    .TIMEOUT    (255)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .ack0      (ack0),
    .ack1      (ack1),
    .rdata     (rdata),
    .romAddr   (rom_addr),
    .romTrigger(rom_trigger),
    .romData   (rom_data),
    .romReady  (rom_ready),
    .busy      (busy),
    .timeoutErr(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_model(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction

  assign rom_data = rom_model(rom_addr);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    exp_trig = 1'b0;
  endtask

  // Full transaction: raise req, wait for the ack, check it, drop req.
  task automatic run_txn(input bit who, input logic [31:0] addr, input int exp_lat,
                         input string tag);
    int lat;
    bit seen;
    if (who) begin addr1 = addr; req1 = 1'b1; end
    else     begin addr0 = addr; req0 = 1'b1; end
    exp_trig = ~exp_trig;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      tick();
      lat++;
      check({tag, "_mutex"}, 32'(ack0 & ack1), 32'd0);
      if ((who ? ack1 : ack0) === 1'b1) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_other_ack"}, 32'(who ? ack0 : ack1), 32'd0);
    check({tag, "_rdata"}, rdata, rom_model(addr));
    check({tag, "_rom_addr"}, rom_addr, addr);
    check({tag, "_trigger"}, 32'(rom_trigger), 32'(exp_trig));
    if (who) req1 = 1'b0;
    else     req0 = 1'b0;
    tick();
    check({tag, "_ack_fall"}, 32'({ack1, ack0}), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int  waited;
    bit  exp_w;
    rst_n     = 1'b0;
    req0      = 1'b0;
    req1      = 1'b0;
    addr0     = '0;
    addr1     = '0;
    rom_ready = 1'b1;
    exp_trig  = 1'b0;

    // ---------------- Reset state ----------------
    tick();
    tick();
    check("rst_ack", 32'({ack1, ack0}), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_rom_addr", rom_addr, 32'd0);
    check("rst_trigger", 32'(rom_trigger), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_terr", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();

    // ---------------- Basic fetch, cycle by cycle ----------------
    addr0 = 32'h10;
    req0  = 1'b1;
    tick();                                   // after E0: grant
    check("b_grant_addr", rom_addr, 32'h10);
    check("b_grant_busy", 32'(busy), 32'd1);
    check("b_grant_trig", 32'(rom_trigger), 32'd0);
    tick();                                   // after E0+1: ISSUE toggled
    check("b_issue_trig", 32'(rom_trigger), 32'd1);
    tick();
    check("b_e2_ack", 32'(ack0), 32'd0);
    tick();
    check("b_e3_ack", 32'(ack0), 32'd0);
    tick();                                   // after E0+4: ack
    check("b_e4_ack0", 32'(ack0), 32'd1);
    check("b_e4_ack1", 32'(ack1), 32'd0);
    check("b_e4_rdata", rdata, 32'hDEAD_BEEF);
    check("b_e4_trig_once", 32'(rom_trigger), 32'd1);
    check("b_e4_rom_addr", rom_addr, 32'h10);
    tick();
    check("b_hold_ack0", 32'(ack0), 32'd1);
    req0 = 1'b0;
    tick();
    check("b_fall_ack0", 32'(ack0), 32'd0);
    check("b_fall_busy", 32'(busy), 32'd0);

    // ---------------- Round-robin alternation ----------------
    do_reset();
    addr0 = 32'h100;
    addr1 = 32'h200;
    req0  = 1'b1;
    req1  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_w    = (i % 2) != 0;
      exp_trig = ~exp_trig;
      waited   = 0;
      while (ack0 !== 1'b1 && ack1 !== 1'b1 && waited < 20) begin
        tick();
        waited++;
        check("rr_mutex", 32'(ack0 & ack1), 32'd0);
      end
      check("rr_winner_ack1", 32'(ack1), 32'(exp_w));
      check("rr_winner_ack0", 32'(ack0), 32'(!exp_w));
      check("rr_rom_addr", rom_addr, exp_w ? 32'h200 : 32'h100);
      check("rr_rdata", rdata, rom_model(exp_w ? 32'h200 : 32'h100));
      check("rr_trigger", 32'(rom_trigger), 32'(exp_trig));
      if (i == 3) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end else if (exp_w) begin
        req1 = 1'b0;
      end else begin
        req0 = 1'b0;
      end
      tick();
      check("rr_ack_fall", 32'({ack1, ack0}), 32'd0);
      if (i < 3) begin
        if (exp_w) req1 = 1'b1;
        else       req0 = 1'b1;
      end
    end
    tick();
    check("rr_end_idle", 32'(busy), 32'd0);

    // ---------------- Timeout forced capture ----------------
    rom_ready = 1'b0;
    tick();
    tick();
    tick();
    check("tmo_pre_terr", 32'(timeout_err), 32'd0);
    run_txn(1'b0, 32'h20, 258, "tmo");
    check("tmo_terr_set", 32'(timeout_err), 32'd1);
    rom_ready = 1'b1;
    tick();
    tick();
    tick();
    run_txn(1'b1, 32'h24, 5, "post_tmo");
    check("tmo_terr_sticky", 32'(timeout_err), 32'd1);

    // ---------------- Requester drops during WAIT ----------------
    addr1    = 32'h300;
    req1     = 1'b1;
    exp_trig = ~exp_trig;
    tick();
    check("drop_grant_addr", rom_addr, 32'h300);
    tick();
    tick();                                   // now in WAIT
    req1 = 1'b0;
    tick();
    check("drop_e3_busy", 32'(busy), 32'd1);
    check("drop_e3_ack1", 32'(ack1), 32'd0);
    tick();                                   // access completes here
    check("drop_done_busy", 32'(busy), 32'd0);
    check("drop_done_ack1", 32'(ack1), 32'd0);
    check("drop_rdata_kept", rdata, rom_model(32'h24));
    check("drop_trigger", 32'(rom_trigger), 32'(exp_trig));
    tick();
    check("drop_after_ack1", 32'(ack1), 32'd0);

    // ---------------- Reset during WAIT ----------------
    addr0 = 32'h40;
    req0  = 1'b1;
    tick();
    tick();
    tick();                                   // in WAIT
    rst_n = 1'b0;
    req0  = 1'b0;
    tick();
    check("mrst_ack", 32'({ack1, ack0}), 32'd0);
    check("mrst_rdata", rdata, 32'd0);
    check("mrst_rom_addr", rom_addr, 32'd0);
    check("mrst_trigger", 32'(rom_trigger), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_terr", 32'(timeout_err), 32'd0);
    rst_n    = 1'b1;
    exp_trig = 1'b0;
    tick();
    tick();
    run_txn(1'b0, 32'h44, 5, "after_rst");

    // ---------------- Request arriving while ack0 is high ----------------
    addr0 = 32'h50;
    req0  = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("pend_ack0", 32'(ack0), 32'd1);
    addr1 = 32'h400;
    req1  = 1'b1;
    tick();
    check("pend_hold_ack0", 32'(ack0), 32'd1);
    check("pend_hold_ack1", 32'(ack1), 32'd0);
    check("pend_hold_addr", rom_addr, 32'h50);
    req0 = 1'b0;
    tick();                                   // ack0 fell, IDLE
    check("pend_fall_ack0", 32'(ack0), 32'd0);
    check("pend_fall_busy", 32'(busy), 32'd0);
    check("pend_fall_addr", rom_addr, 32'h50);
    tick();                                   // first IDLE cycle grants req1
    check("pend_grant_busy", 32'(busy), 32'd1);
    check("pend_grant_addr", rom_addr, 32'h400);
    check("pend_grant_ack1", 32'(ack1), 32'd0);
    for (int k = 0; k < 4; k++) tick();
    check("pend_ack1", 32'(ack1), 32'd1);
    check("pend_ack1_excl", 32'(ack0), 32'd0);
    check("pend_rdata", rdata, rom_model(32'h400));
    req1 = 1'b0;
    tick();
    check("pend_end_ack1", 32'(ack1), 32'd0);
    check("pend_end_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
